// File: rtl/instr_exec_pkg.sv
// Shared opcode type and default sizing for the instruction-execute register file.
package instr_exec_pkg;

  localparam int DEF_OP_W  = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7,
    POW   = 4'd8
  } opcode_t;

endpackage

// File: rtl/instr_pow_unit.sv
// Iterative signed power, square-and-multiply over the exponent MSB first, fixed OP_W steps.
// done is high during the final step so the caller writes result on that same edge.
module instr_pow_unit #(
  parameter int OP_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [OP_W-1:0]     base,
  input  logic [OP_W-1:0]     exponent,
  output logic                busy,
  output logic                done,
  output logic [2*OP_W-1:0]   result,
  output logic                err
);

  localparam int RW = 2 * OP_W;
  localparam int CW = $clog2(OP_W);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] POW_RUN = 1'b1;

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   base_q;
  logic [RW-1:0]   acc_q;
  logic [RW-1:0]   acc_sq;
  logic [RW-1:0]   acc_next;
  logic [OP_W-1:0] exp_q;
  logic            err_q;

  // Products wrap modulo 2^RW, which is exactly the truncated two's-complement result.
  always_comb begin
    acc_sq   = acc_q * acc_q;
    acc_next = exp_q[OP_W-1] ? acc_sq * base_q : acc_sq;
  end

  assign busy   = (state == POW_RUN);
  assign done   = busy && (cnt == CW'(OP_W - 1));
  assign result = err_q ? '0 : acc_next;
  assign err    = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      base_q <= '0;
      acc_q  <= '0;
      exp_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= POW_RUN;
            cnt    <= '0;
            base_q <= {{OP_W{base[OP_W-1]}}, base};
            acc_q  <= RW'(1);
            exp_q  <= exponent;
            err_q  <= exponent[OP_W-1];
          end
        end
        default: begin
          acc_q <= acc_next;
          exp_q <= exp_q << 1;
          cnt   <= cnt + CW'(1);
          if (done) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_exec_regfile.sv
// Instruction-execute register file: one staged write port, combinational read port.
// Define INSTR_POW_UNIT_EN to build the iterative POW unit; otherwise POW stores an error.
module instr_exec_regfile
  import instr_exec_pkg::*;
#(
  parameter  int OP_W  = DEF_OP_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            opcode,
  input  logic [OP_W-1:0]       operand_a,
  input  logic [OP_W-1:0]       operand_b,
  input  logic [AW-1:0]         write_pointer,
  input  logic [AW-1:0]         read_pointer,
  output logic [4+4*OP_W-1:0]   instruction_word,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic                  busy
);

  localparam int RW = 2 * OP_W;
  localparam int IW = 4 + 4 * OP_W;

  logic                 ready_q;
  logic                 accept;
  logic                 stg_valid;
  logic [3:0]           stg_op;
  logic [OP_W-1:0]      stg_a;
  logic [OP_W-1:0]      stg_b;
  logic [AW-1:0]        stg_wp;
  logic                 stg_is_pow;
  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic [RW-1:0]        stg_res;
  logic                 stg_err;
  logic [3:0]           stg_op_st;
  logic [OP_W-1:0]      stg_a_st;
  logic [OP_W-1:0]      stg_b_st;
  logic                 pow_busy;
  logic                 pow_block;
  logic                 wr_en;
  logic [AW-1:0]        wr_idx;
  logic [IW-1:0]        wr_word;
  logic                 wr_err;
  logic [IW-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [DEPTH-1:0]     err_q;

  assign stg_is_pow = (stg_op == POW);
  assign wr_ready   = ready_q && !pow_block;
  assign accept     = wr_valid && wr_ready;
  assign busy       = stg_valid || pow_busy;

  // ready_q keeps wr_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      stg_valid <= 1'b0;
      stg_op    <= '0;
      stg_a     <= '0;
      stg_b     <= '0;
      stg_wp    <= '0;
    end else begin
      ready_q   <= 1'b1;
      stg_valid <= accept;
      if (accept) begin
        stg_op <= opcode;
        stg_a  <= operand_a;
        stg_b  <= operand_b;
        stg_wp <= write_pointer;
      end
    end
  end

  // Single-cycle ALU on the stage register; illegal opcodes collapse to an all-zero error entry.
  always_comb begin
    a_ext     = {{OP_W{stg_a[OP_W-1]}}, stg_a};
    b_ext     = {{OP_W{stg_b[OP_W-1]}}, stg_b};
    stg_res   = '0;
    stg_err   = 1'b0;
    stg_op_st = stg_op;
    stg_a_st  = stg_a;
    stg_b_st  = stg_b;
    case (stg_op)
      ZERO:  stg_res = '0;
      PASSA: stg_res = a_ext;
      PASSB: stg_res = b_ext;
      ADD:   stg_res = a_ext + b_ext;
      SUB:   stg_res = a_ext - b_ext;
      MULT:  stg_res = a_ext * b_ext;
      DIV: begin
        if (b_ext == '0) stg_err = 1'b1;
        else             stg_res = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == '0) stg_err = 1'b1;
        else             stg_res = a_ext % b_ext;
      end
      POW:   stg_err = 1'b1;
      default: begin
        stg_err   = 1'b1;
        stg_op_st = ZERO;
        stg_a_st  = '0;
        stg_b_st  = '0;
      end
    endcase
  end

`ifdef INSTR_POW_UNIT_EN
  logic            pow_start;
  logic            pow_done;
  logic            pow_err;
  logic [RW-1:0]   pow_res;
  logic [OP_W-1:0] pow_a;
  logic [OP_W-1:0] pow_b;
  logic [AW-1:0]   pow_wp;

  assign pow_start = stg_valid && stg_is_pow;
  // Writes reopen during the POW's final step so the next op can land right behind it.
  assign pow_block = pow_start || (pow_busy && !pow_done);

  instr_pow_unit #(.OP_W(OP_W)) u_pow (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (pow_start),
    .base     (stg_a),
    .exponent (stg_b),
    .busy     (pow_busy),
    .done     (pow_done),
    .result   (pow_res),
    .err      (pow_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pow_a  <= '0;
      pow_b  <= '0;
      pow_wp <= '0;
    end else if (pow_start) begin
      pow_a  <= stg_a;
      pow_b  <= stg_b;
      pow_wp <= stg_wp;
    end
  end

  always_comb begin
    wr_en   = stg_valid && !stg_is_pow;
    wr_idx  = stg_wp;
    wr_word = {stg_op_st, stg_a_st, stg_b_st, stg_res};
    wr_err  = stg_err;
    if (pow_done) begin
      wr_en   = 1'b1;
      wr_idx  = pow_wp;
      wr_word = {POW, pow_a, pow_b, pow_res};
      wr_err  = pow_err;
    end
  end
`else
  assign pow_busy  = 1'b0;
  assign pow_block = 1'b0;

  always_comb begin
    wr_en   = stg_valid;
    wr_idx  = stg_wp;
    wr_word = {stg_op_st, stg_a_st, stg_b_st, stg_res};
    wr_err  = stg_err;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld_q <= '0;
      err_q <= '0;
    end else if (wr_en) begin
      mem[wr_idx]   <= wr_word;
      vld_q[wr_idx] <= 1'b1;
      err_q[wr_idx] <= wr_err;
    end
  end

  assign instruction_word = mem[read_pointer];
  assign rd_valid         = vld_q[read_pointer];
  assign rd_err           = err_q[read_pointer];

endmodule

// File: tb/tb_instr_exec_regfile.sv
// Scoreboard bench for instr_exec_regfile: expected entries queued at drive time, checked via the read port.
module tb_instr_exec_regfile;
  import instr_exec_pkg::*;

  localparam int OP_W  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int IW    = 4 + 4 * OP_W;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [3:0]      opcode = '0;
  logic [OP_W-1:0] operand_a = '0;
  logic [OP_W-1:0] operand_b = '0;
  logic [AW-1:0]   write_pointer = '0;
  logic [AW-1:0]   read_pointer = '0;
  logic [IW-1:0]   instruction_word;
  logic            rd_valid;
  logic            rd_err;
  logic            busy;

  typedef struct {
    int            wp;
    logic [IW-1:0] word;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  instr_exec_regfile #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid),
    .rd_err           (rd_err),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Reference behaviour; POW uses plain repeated multiplication with 64-bit wrap.
  function automatic exp_t model(input logic [3:0] op, input int a, input int b, input int wp);
    exp_t       x;
    longint     r;
    logic       e;
    logic [3:0] so;
    int         sa;
    int         sb;
    r = 0; e = 1'b0; so = op; sa = a; sb = b;
    case (op)
      ZERO:  r = 0;
      PASSA: r = longint'(a);
      PASSB: r = longint'(b);
      ADD:   r = longint'(a) + longint'(b);
      SUB:   r = longint'(a) - longint'(b);
      MULT:  r = longint'(a) * longint'(b);
      DIV:   if (b == 0) e = 1'b1; else r = longint'(a) / longint'(b);
      MOD:   if (b == 0) e = 1'b1; else r = longint'(a) % longint'(b);
      POW: begin
`ifdef INSTR_POW_UNIT_EN
        if (b < 0) e = 1'b1;
        else begin
          r = 1;
          for (int i = 0; i < b; i++) r = r * longint'(a);
        end
`else
        e = 1'b1;
`endif
      end
      default: begin
        e = 1'b1; so = 4'd0; sa = 0; sb = 0;
      end
    endcase
    x.wp = wp;
    x.word = {so, sa, sb, r};
    x.err = e;
    return x;
  endfunction

  // A newer write to the same entry supersedes any queued expectation for it.
  function automatic void sb_push(input exp_t x);
    for (int k = sb_q.size() - 1; k >= 0; k--)
      if (sb_q[k].wp == x.wp) sb_q.delete(k);
    sb_q.push_back(x);
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input int a, input int b, input int wp);
    int guard;
    guard = 0;
    @(negedge clk);
    while (wr_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (wr_ready !== 1'b1) begin
      checks++;
      $display("[TB] FAIL ready_timeout wr_ready=%b required 1", wr_ready);
    end
    wr_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = AW'(wp);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++; if (instruction_word !== '0) $display("[TB] FAIL rst_word got %h required 0", instruction_word); else passes++;
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL rst_rd_valid got %b required 0", rd_valid); else passes++;
    checks++; if (rd_err !== 1'b0) $display("[TB] FAIL rst_rd_err got %b required 0", rd_err); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy got %b required 0", busy); else passes++;
    checks++; if (wr_ready !== 1'b0) $display("[TB] FAIL rst_wr_ready got %b required 0", wr_ready); else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr_ready !== 1'b0) $display("[TB] FAIL rst_wr_ready_edges got %b required 0", wr_ready); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0) $display("[TB] FAIL rel_wr_ready got %b required 0", wr_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL rel_edge_wr_ready got %b required 1", wr_ready); else passes++;
  endtask

  task automatic test_add();
    exp_t x;
    applyStimulus(ADD, 7, -3, 5);
    sb_push(model(ADD, 7, -3, 5));
    read_pointer = 5; #1;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL add_busy got %b required 1", busy); else passes++;
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL add_prewrite_valid got %b required 0", rd_valid); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL add_busy_after got %b required 0", busy); else passes++;
    checks++; if (instruction_word[63:0] !== 64'd4) $display("[TB] FAIL add_result got %h required 4", instruction_word[63:0]); else passes++;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      read_pointer = AW'(x.wp); #1;
      checks++;
      if (instruction_word !== x.word || rd_valid !== 1'b1 || rd_err !== x.err)
        $display("[TB] FAIL add_entry wp=%0d got %h v=%b e=%b required %h v=1 e=%b", x.wp, instruction_word, rd_valid, rd_err, x.word, x.err);
      else passes++;
    end
  endtask

  task automatic test_div_mult();
    exp_t x;
    applyStimulus(DIV, 9, 0, 2);
    sb_push(model(DIV, 9, 0, 2));
    @(posedge clk); #1;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      read_pointer = AW'(x.wp); #1;
      checks++;
      if (instruction_word !== x.word || rd_valid !== 1'b1 || rd_err !== x.err)
        $display("[TB] FAIL div0_entry wp=%0d got %h v=%b e=%b required %h v=1 e=%b", x.wp, instruction_word, rd_valid, rd_err, x.word, x.err);
      else passes++;
    end
    applyStimulus(MULT, -2, 32'h7FFF_FFFF, 2);
    sb_push(model(MULT, -2, 32'h7FFF_FFFF, 2));
    read_pointer = 2; #1;
    checks++; if (rd_err !== 1'b1) $display("[TB] FAIL mult_prewrite_err got %b required 1", rd_err); else passes++;
    @(posedge clk); #1;
    checks++; if (instruction_word[63:0] !== 64'hFFFF_FFFF_0000_0002) $display("[TB] FAIL mult_result got %h required ffffffff00000002", instruction_word[63:0]); else passes++;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      read_pointer = AW'(x.wp); #1;
      checks++;
      if (instruction_word !== x.word || rd_valid !== 1'b1 || rd_err !== x.err)
        $display("[TB] FAIL mult_entry wp=%0d got %h v=%b e=%b required %h v=1 e=%b", x.wp, instruction_word, rd_valid, rd_err, x.word, x.err);
      else passes++;
    end
  endtask

  task automatic test_ops();
    exp_t       x;
    logic [3:0] ops [9] = '{SUB, PASSA, PASSB, DIV, MOD, MOD, ZERO, 4'hF, DIV};
    int         as  [9] = '{5, -8, 3, -7, -7, 5, 100, 1, 32'h8000_0000};
    int         bs  [9] = '{12, 1, -9, 2, 2, 0, 200, 2, -1};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 6 + i);
      sb_push(model(ops[i], as[i], bs[i], 6 + i));
    end
    @(posedge clk); #1;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      read_pointer = AW'(x.wp); #1;
      checks++;
      if (instruction_word !== x.word || rd_valid !== 1'b1 || rd_err !== x.err)
        $display("[TB] FAIL ops_entry wp=%0d got %h v=%b e=%b required %h v=1 e=%b", x.wp, instruction_word, rd_valid, rd_err, x.word, x.err);
      else passes++;
    end
  endtask

  task automatic test_pow();
    exp_t x;
    int   low;
    int   guard;
    applyStimulus(POW, 3, 4, 1);
    sb_push(model(POW, 3, 4, 1));
`ifdef INSTR_POW_UNIT_EN
    low = 0;
    @(negedge clk);
    wr_valid = 1'b1; opcode = ADD; operand_a = 1; operand_b = 1; write_pointer = 9;
    while (wr_ready === 1'b0 && low < 100) begin
      low++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    checks++; if (low != 32) $display("[TB] FAIL pow_ready_low_cycles got %0d required 32", low); else passes++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL pow_busy_last got %b required 1", busy); else passes++;
    read_pointer = 1; #1;
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL pow_early_valid got %b required 0", rd_valid); else passes++;
    @(posedge clk); #1;
    checks++; if (instruction_word[63:0] !== 64'd81) $display("[TB] FAIL pow_result got %h required 81", instruction_word[63:0]); else passes++;
    read_pointer = 9; #1;
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL pow_blocked_write got %b required 0", rd_valid); else passes++;
    applyStimulus(POW, 0, 0, 15);
    sb_push(model(POW, 0, 0, 15));
    applyStimulus(POW, -2, 3, 17);
    sb_push(model(POW, -2, 3, 17));
    applyStimulus(POW, 2, -1, 16);
    sb_push(model(POW, 2, -1, 16));
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (busy !== 1'b0) $display("[TB] FAIL pow_busy_timeout got %b required 0", busy); else passes++;
`else
    low = 0;
    guard = 0;
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL pow_off_ready got %b required 1", wr_ready); else passes++;
    @(posedge clk); #1;
`endif
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      read_pointer = AW'(x.wp); #1;
      checks++;
      if (instruction_word !== x.word || rd_valid !== 1'b1 || rd_err !== x.err)
        $display("[TB] FAIL pow_entry wp=%0d got %h v=%b e=%b required %h v=1 e=%b", x.wp, instruction_word, rd_valid, rd_err, x.word, x.err);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL b2b_ready i=%0d got %b required 1", i, wr_ready); else passes++;
      wr_valid = 1'b1; opcode = ADD; operand_a = i * 3; operand_b = -i; write_pointer = AW'(i % 32);
      sb_push(model(ADD, i * 3, -i, i % 32));
    end
    @(negedge clk);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (sb_q.size() != 32) $display("[TB] FAIL b2b_queue got %0d required 32", sb_q.size()); else passes++;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      read_pointer = AW'(x.wp); #1;
      checks++;
      if (instruction_word !== x.word || rd_valid !== 1'b1 || rd_err !== x.err)
        $display("[TB] FAIL b2b_entry wp=%0d got %h v=%b e=%b required %h v=1 e=%b", x.wp, instruction_word, rd_valid, rd_err, x.word, x.err);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_pow();
    int nvalid;
`ifdef INSTR_POW_UNIT_EN
    applyStimulus(POW, 5, 3, 3);
    repeat (10) @(negedge clk);
`else
    applyStimulus(ADD, 5, 3, 3);
`endif
    checks++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy got %b required 1", busy); else passes++;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_rst_busy got %b required 0", busy); else passes++;
    checks++; if (wr_ready !== 1'b0) $display("[TB] FAIL mid_rst_ready got %b required 0", wr_ready); else passes++;
    nvalid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      read_pointer = AW'(i); #1;
      if (rd_valid !== 1'b0) nvalid++;
    end
    checks++; if (nvalid != 0) $display("[TB] FAIL mid_rst_valid_count got %0d required 0", nvalid); else passes++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (wr_ready !== 1'b1) $display("[TB] FAIL mid_rel_ready got %b required 1", wr_ready); else passes++;
    repeat (40) @(posedge clk);
    #1;
    read_pointer = 3; #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL mid_dropped got v=%b busy=%b required 0/0", rd_valid, busy); else passes++;
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_div_mult();
    test_ops();
    test_pow();
    test_back_to_back();
    test_reset_mid_pow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached, passed %0d of %0d", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/instr_exec_regfile.md
INSTR_EXEC_REGFILE -- requirements
Module: instr_exec_regfile

Interface
REQ-001 SHALL have parameter OP_W, default 32, operand width in bits (range 8..64).
REQ-002 SHALL have parameter DEPTH, default 32, entry count (power of two, 4..256); AW = $clog2(DEPTH), derived.
REQ-003 SHALL have port clk  input  1  clock, rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  write request.
REQ-006 SHALL have port wr_ready  output  1  block can accept a write.
REQ-007 SHALL have port opcode  input  4  opcode_t operation.
REQ-008 SHALL have ports operand_a and operand_b  input  OP_W  signed operands.
REQ-009 SHALL have port write_pointer  input  AW  target entry.
REQ-010 SHALL have port read_pointer  input  AW  read entry.
REQ-011 SHALL have port instruction_word  output  4+4*OP_W  {opcode, operand_a, operand_b, result[2*OP_W-1:0]} of entry read_pointer.
REQ-012 SHALL have port rd_valid  output  1  entry read_pointer written since reset.
REQ-013 SHALL have port rd_err  output  1  entry read_pointer holds an error result.
REQ-014 SHALL have port busy  output  1  a write is in flight.

Function
REQ-015 Write accepted on a rising edge where wr_valid && wr_ready; inputs captured into a stage register at that edge (cycle N).
REQ-016 Non-POW ops: result computed from the stage register and written to the array at edge N+1; new accepts allowed back-to-back.
REQ-017 Results: ZERO 0; PASSA a; PASSB b; ADD a+b; SUB a-b; MULT a*b; DIV a/b; MOD a%b; sign-extended to 2*OP_W, product full width.
REQ-018 DIV/MOD with b==0: result 0, err=1; opcode values not in opcode_t: entry stored as ZERO/all-zero, err=1.
REQ-019 POW: FSM IDLE -> POW_RUN -> IDLE; square-and-multiply over b, fixed OP_W iterations; result written at edge N+OP_W+1, truncated to 2*OP_W bits.
REQ-020 POW with b negative: result 0, err=1; with a==0 and b==0: result 1.
REQ-021 wr_ready SHALL be 0 from the edge after a POW accept until the edge the POW result is written; 1 otherwise.
REQ-022 busy SHALL be 1 while the stage register or the POW FSM holds an unwritten op.
REQ-023 Read port combinational from array; read and write to the same entry in one cycle returns the pre-write value.
REQ-024 Rewriting an entry overwrites all fields, including err; write_pointer wrap is natural (AW bits, no checking).

Reset
REQ-025 reset_n low SHALL immediately clear all entries to zero, all valid/err bits, stage register, and the POW FSM (to IDLE).
REQ-026 During reset, outputs: instruction_word 0, rd_valid 0, rd_err 0, busy 0, wr_ready 0; wr_ready rises 1 on the first edge after reset release.
REQ-027 Reset during an in-flight POW SHALL drop the op; nothing is written.

Configuration
REQ-028 Macro INSTR_POW_UNIT_EN defined: POW behaves per REQ-019..021.
REQ-029 INSTR_POW_UNIT_EN undefined: no POW hardware; POW treated as a non-POW op storing result 0, err=1, latency 1; wr_ready never drops.

Structure
REQ-030 Shared package instr_exec_pkg SHALL hold opcode_t (4-bit enum ZERO..POW) and default parameter constants.
REQ-031 Iterative power SHALL be sub-module instr_pow_unit (start/done handshake), instantiated only under INSTR_POW_UNIT_EN.

Verification (OP_W=32, DEPTH=32)
REQ-032 ADD a=7,b=-3 at wp=5 -> entry 5 result 4, rd_valid=1, rd_err=0 after edge N+1.
REQ-033 DIV a=9,b=0 at wp=2 -> result 0, rd_err=1; then MULT a=-2,b=0x7FFFFFFF at wp=2 -> result -0xFFFFFFFE (64-bit), rd_err=0.
REQ-034 POW a=3,b=4 at wp=1 -> wr_ready 0 for 32 cycles, entry 1 result 81 at edge N+33; write offered during busy not accepted.
REQ-035 Back-to-back ADDs to wp=0..31 then wp=0 again -> all 32 entries correct, entry 0 overwritten.
REQ-036 reset_n pulsed mid-POW -> all rd_valid 0, busy 0, no result written, wr_ready 1 after release.
